// File: rtl/cache_pkg.sv
// ---------------------------------------------------------------------------
// cache_pkg
// Shared types and constants for the cache miss arbiter and its helpers.
//   WORDS_PER_BLOCK : words in one cache block
//   BLOCK_OFFSET_W  : byte-offset bits within a block (16-bit words)
//   arb_state_t     : arbiter FSM states
//   arb_owner_t     : which cache owns the fill in flight
//   cnt_width()     : width of a block word counter (must hold WORDS itself)
// ---------------------------------------------------------------------------
package cache_pkg;

    localparam int WORDS_PER_BLOCK = 8;
    localparam int BLOCK_OFFSET_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DONE  = 2'd2,
        WRITE = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

    function automatic int cnt_width(input int words);
        return $clog2(words) + 1;
    endfunction

endpackage

// File: rtl/block_word_counter.sv
// ---------------------------------------------------------------------------
// block_word_counter
// Counts words of a block fill. Clear wins over enable. o_term flags that the
// count currently equals TERM (WORDS for "all issued", WORDS-1 for "last").
//   clk, rst_n : clock, asynchronous active-low reset
//   i_clr      : synchronous clear to 0
//   i_en       : increment by one
//   o_count    : current count, log2(WORDS)+1 bits
//   o_term     : count == TERM
// ---------------------------------------------------------------------------
module block_word_counter
    import cache_pkg::*;
#(
    parameter int WORDS = WORDS_PER_BLOCK,
    parameter int TERM  = WORDS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_clr,
    input  logic                   i_en,
    output logic [$clog2(WORDS):0] o_count,
    output logic                   o_term
);

    localparam int CNT_W = cnt_width(WORDS);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;
    assign o_term  = (r_count == CNT_W'(TERM));

endmodule

// File: rtl/cache_miss_arbiter.sv
// ---------------------------------------------------------------------------
// cache_miss_arbiter
// Arbitrates I-cache misses, D-cache misses and D-side write-through stores
// onto one pipelined main memory. A miss performs a full block fill: WORDS
// back-to-back reads are issued, and each returned word is streamed into the
// owning cache with its byte address. A store is a single write cycle.
//   clk, rst_n            : clock, asynchronous active-low reset
//   i_miss, i_miss_addr   : I-side miss (level, held until i_fill_done)
//   d_miss, d_miss_addr   : D-side miss (level, held until d_fill_done)
//   d_wr_req/addr/data    : write-through store (level, held until d_wr_ack)
//   i_fill_we, d_fill_we  : write one returned word into that cache
//   fill_addr, fill_data  : byte address / data of the word being filled
//   i_fill_done/d_fill_done : one-cycle block-complete pulses
//   d_wr_ack              : one-cycle pulse, store issued to memory
//   busy                  : arbiter not idle
//   mem_en/wr/addr/wdata  : memory request side
//   mem_rdata, mem_valid  : memory return side (fixed MEM_LAT after mem_en)
// ---------------------------------------------------------------------------
module cache_miss_arbiter
    import cache_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int WORDS   = WORDS_PER_BLOCK,
    parameter int MEM_LAT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_miss,
    input  logic [ADDR_W-1:0] i_miss_addr,
    input  logic              d_miss,
    input  logic [ADDR_W-1:0] d_miss_addr,
    input  logic              d_wr_req,
    input  logic [ADDR_W-1:0] d_wr_addr,
    input  logic [DATA_W-1:0] d_wr_data,
    output logic              i_fill_we,
    output logic              d_fill_we,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [DATA_W-1:0] fill_data,
    output logic              i_fill_done,
    output logic              d_fill_done,
    output logic              d_wr_ack,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_valid
);

    localparam int CNT_W = cnt_width(WORDS);
    // Block base clears the byte offset of a WORDS-word block of 2-byte words.
    localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'(2 * WORDS - 1);

    // Returns are counted rather than timed, so any fixed latency works, but
    // the block must be a power of two for the base mask to be meaningful.
    if (MEM_LAT < 1 || (WORDS & (WORDS - 1)) != 0) begin : g_param_check
        $error("cache_miss_arbiter: WORDS must be a power of two and MEM_LAT >= 1");
    end

    arb_state_t        r_state, w_next;
    arb_owner_t        r_owner;
    logic [ADDR_W-1:0] r_base;

    logic             w_start_miss;
    logic             w_iss_en, w_iss_full;
    logic             w_fill, w_rcv_last;
    logic [CNT_W-1:0] w_iss_cnt, w_rcv_cnt;

    // Issue side runs ahead of returns; it stops once all WORDS are issued.
    assign w_iss_en = (r_state == FILL) && !w_iss_full;
    // Only returns during FILL count; stray valids elsewhere are dropped.
    assign w_fill   = (r_state == FILL) && mem_valid;

    block_word_counter #(.WORDS(WORDS), .TERM(WORDS)) u_iss_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_start_miss),
        .i_en    (w_iss_en),
        .o_count (w_iss_cnt),
        .o_term  (w_iss_full)
    );

    block_word_counter #(.WORDS(WORDS), .TERM(WORDS - 1)) u_rcv_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_start_miss),
        .i_en    (w_fill),
        .o_count (w_rcv_cnt),
        .o_term  (w_rcv_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_owner <= OWN_I;
            r_base  <= '0;
        end else begin
            r_state <= w_next;
            if (w_start_miss) begin
                r_owner <= i_miss ? OWN_I : OWN_D;
                r_base  <= (i_miss ? i_miss_addr : d_miss_addr) & BLK_MASK;
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        w_start_miss = 1'b0;
        mem_en       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        d_wr_ack     = 1'b0;
        i_fill_done  = 1'b0;
        d_fill_done  = 1'b0;
        busy         = (r_state != IDLE);

        case (r_state)
            IDLE: begin
                // Level requests are re-evaluated here every time; I wins.
                if (i_miss || d_miss) begin
                    w_next       = FILL;
                    w_start_miss = 1'b1;
                end else if (d_wr_req) begin
                    w_next = WRITE;
                end
            end
            FILL: begin
                if (w_iss_en) begin
                    mem_en   = 1'b1;
                    mem_addr = r_base + (ADDR_W'(w_iss_cnt) << 1);
                end
                if (w_fill && w_rcv_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                i_fill_done = (r_owner == OWN_I);
                d_fill_done = (r_owner == OWN_D);
                w_next      = IDLE;
            end
            WRITE: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = d_wr_addr;
                mem_wdata = d_wr_data;
                d_wr_ack  = 1'b1;
                w_next    = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Fill path is combinational from the memory return.
    assign i_fill_we = w_fill && (r_owner == OWN_I);
    assign d_fill_we = w_fill && (r_owner == OWN_D);
    assign fill_addr = w_fill ? r_base + (ADDR_W'(w_rcv_cnt) << 1) : '0;
    assign fill_data = w_fill ? mem_rdata : '0;

endmodule
